// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: central pipeline sequencer for the five-stage core.
//
// Watches ID, EX and MEM and drives the write enables / flushes of the PC,
// IF/ID, ID/EX and EX/MEM registers. Handles, in fixed priority order:
// data-memory freeze, EX redirect, mul/div occupancy stall, load-use stall.
//
// Configuration macro:
//   DELAY_SLOT_EN  defined   -> redirect kills only IF/ID (delay slot advances)
//                  undefined -> redirect flushes both IF/ID and ID/EX
//
// Ports:
//   clk, reset                  clock (rising edge), synchronous active-high reset
//   id_rs, id_rt                source registers of the ID instruction
//   id_uses_rs, id_uses_rt      ID instruction actually reads rs / rt
//   id_is_md                    ID instruction uses the mul/div unit
//   ex_mem_read, ex_rt          EX instruction is a load, and its destination
//   ex_md_start                 EX instruction starts the mul/div unit
//   ex_redirect                 EX resolved a taken branch / jump
//   mem_req, mem_ready          MEM access pending / data memory done
//   pc_wen .. exmem_wen         register write enables (combinational)
//   ifid_flush, idex_flush      bubble insertion (combinational)
//   md_busy                     registered, high in MD_BUSY
//   state                       registered: 00 RUN, 01 MD_BUSY, 10 MEM_WAIT
module hazard_stall_ctrl #(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_is_md,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       ex_md_start,
    input  logic       ex_redirect,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_wen,
    output logic       ifid_wen,
    output logic       idex_wen,
    output logic       exmem_wen,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       md_busy,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StMdBusy  = 2'b01,
        StMemWait = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] MdLoad = CNT_W'(MD_LATENCY - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             md_busy_q;

    logic freeze;
    logic md_stall;
    logic load_use;

    assign freeze   = mem_req && !mem_ready;
    assign md_stall = (state_q == StMdBusy) && id_is_md;
    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rt)) ||
                       (id_uses_rt && (id_rt == ex_rt)));

    // Output decode, first match wins.
    always_comb begin
        pc_wen     = 1'b1;
        ifid_wen   = 1'b1;
        idex_wen   = 1'b1;
        exmem_wen  = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (reset) begin
            pc_wen     = 1'b0;
            ifid_wen   = 1'b0;
            idex_wen   = 1'b0;
            exmem_wen  = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (freeze) begin
            // Whole pipe holds; a redirect in EX stays pending until mem_ready.
            pc_wen    = 1'b0;
            ifid_wen  = 1'b0;
            idex_wen  = 1'b0;
            exmem_wen = 1'b0;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
`ifdef DELAY_SLOT_EN
            idex_flush = 1'b0;
`else
            idex_flush = 1'b1;
`endif
        end else if (md_stall || load_use) begin
            pc_wen     = 1'b0;
            ifid_wen   = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Sequencer state, mul/div counter and registered md_busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StRun;
            cnt_q     <= '0;
            md_busy_q <= 1'b0;
        end else begin
            // The mul/div unit runs independently of the pipe, so the counter
            // keeps draining through a freeze; a start is only taken when EX moves.
            if (!freeze && ex_md_start) begin
                cnt_q <= MdLoad;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if (freeze) begin
                state_q   <= StMemWait;
                md_busy_q <= 1'b0;
            end else if (ex_md_start) begin
                // Also taken straight out of MEM_WAIT: the start instruction was
                // held in EX during the freeze and must not be lost.
                state_q   <= StMdBusy;
                md_busy_q <= 1'b1;
            end else begin
                unique case (state_q)
                    StMemWait: begin
                        if (cnt_q != '0) begin
                            state_q   <= StMdBusy;
                            md_busy_q <= 1'b1;
                        end else begin
                            state_q   <= StRun;
                            md_busy_q <= 1'b0;
                        end
                    end
                    StMdBusy: begin
                        if (cnt_q == '0) begin
                            state_q   <= StRun;
                            md_busy_q <= 1'b0;
                        end
                    end
                    StRun: begin
                        md_busy_q <= 1'b0;
                    end
                    default: begin
                        state_q   <= StRun;
                        md_busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign md_busy = md_busy_q;
    assign state   = state_q;

endmodule
